// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states,
// opcode/funct values, datapath select codes and the control-word struct.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_ADDR, S_MEMRD, S_WB_MEM, S_MEMWR, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_EXT = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  typedef struct packed {
    logic       pcwr;
    logic       pcwrcond;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       irwr;
    logic       regdst;
    logic       memtoreg;
    logic       regwr;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctr;
    logic       extop;
    logic       ill;
    logic       retire;
  } ctl_t;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational op/func decode: ALU operation, immediate extension and
// whether the instruction belongs to the supported subset.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [2:0] aluctr,
  output logic       extop,
  output logic       legal
);

  always_comb begin
    aluctr = ALU_ADD;
    extop  = 1'b1;
    legal  = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:          aluctr = ALU_ADD;
          FN_SUB, FN_SUBU: aluctr = ALU_SUB;
          FN_AND:          aluctr = ALU_AND;
          FN_OR:           aluctr = ALU_OR;
          FN_SLT, FN_SLTU: aluctr = ALU_SLT;
          default:         legal  = 1'b0;
        endcase
      end
      // logical immediates are zero-extended
      OP_ANDI: begin aluctr = ALU_AND; extop = 1'b0; end
      OP_ORI:  begin aluctr = ALU_OR;  extop = 1'b0; end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: ;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Moore control FSM for the multi-cycle datapath; outputs are decoded from
// state (plus mem_ready in the handshake states) and held at 0 during reset.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        PCWrCond,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRd,
  output logic        MemWr,
  output logic        IRWr,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWr,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUctr,
  output logic        ExtOp,
  output logic        ill,
  output logic        retire,
  output logic [31:0] instr_cnt
);

  state_t     state, nxt;
  ctl_t       c, co;
  logic [2:0] dec_alu;
  logic       dec_ext, legal;

  mc_alu_dec u_dec (.op(op), .func(func), .aluctr(dec_alu), .extop(dec_ext), .legal(legal));

  always_comb begin
    nxt = state;
    c   = '0;
    case (state)
      S_FETCH: begin
        c.memrd   = 1'b1;
        c.alusrcb = SRCB_4;
        c.irwr    = mem_ready;
        c.pcwr    = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_BR;
        c.extop   = 1'b1;
        c.ill     = !legal;
        nxt       = S_FETCH;
        if (legal) begin
          case (op)
            OP_RTYPE:                           nxt = S_EXEC_R;
            OP_ANDI, OP_ORI, OP_ADDI, OP_ADDIU: nxt = S_EXEC_I;
            OP_LW, OP_SW:                       nxt = S_ADDR;
            OP_BEQ:                             nxt = S_BRANCH;
            OP_J:                               nxt = S_JUMP;
            default:                            nxt = S_FETCH;
          endcase
        end
      end
      S_EXEC_R: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_RT;
        c.aluctr  = dec_alu;
        nxt       = S_WB_R;
      end
      S_WB_R: begin
        c.regdst = 1'b1;
        c.regwr  = 1'b1;
        c.retire = 1'b1;
        nxt      = S_FETCH;
      end
      S_EXEC_I: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_EXT;
        c.aluctr  = dec_alu;
        c.extop   = dec_ext;
        nxt       = S_WB_I;
      end
      S_WB_I: begin
        c.regwr  = 1'b1;
        c.retire = 1'b1;
        nxt      = S_FETCH;
      end
      S_ADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_EXT;
        c.extop   = 1'b1;
        nxt       = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.memrd = 1'b1;
        c.iord  = 1'b1;
        if (mem_ready) nxt = S_WB_MEM;
      end
      S_WB_MEM: begin
        c.memtoreg = 1'b1;
        c.regwr    = 1'b1;
        c.retire   = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEMWR: begin
        c.memwr  = 1'b1;
        c.iord   = 1'b1;
        c.retire = mem_ready;
        if (mem_ready) nxt = S_FETCH;
      end
      S_BRANCH: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = SRCB_RT;
        c.aluctr   = ALU_SUB;
        c.pcwrcond = 1'b1;
        c.pcsrc    = PCS_OUT;
        c.retire   = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        c.pcwr   = 1'b1;
        c.pcsrc  = PCS_JMP;
        c.retire = 1'b1;
        nxt      = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // reset kills writes combinationally, before the state register clears
  assign co = rst ? '0 : c;

  assign PCWr     = co.pcwr;
  assign PCWrCond = co.pcwrcond;
  assign PCSrc    = co.pcsrc;
  assign IorD     = co.iord;
  assign MemRd    = co.memrd;
  assign MemWr    = co.memwr;
  assign IRWr     = co.irwr;
  assign RegDst   = co.regdst;
  assign MemtoReg = co.memtoreg;
  assign RegWr    = co.regwr;
  assign ALUSrcA  = co.alusrca;
  assign ALUSrcB  = co.alusrcb;
  assign ALUctr   = co.aluctr;
  assign ExtOp    = co.extop;
  assign ill      = co.ill;
  assign retire   = co.retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      instr_cnt <= '0;
    end else begin
      state <= nxt;
      if (c.retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model lists the expected control
// word for every cycle of each instruction; one process compares each negedge.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pcwr;
    logic       pcwrcond;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       irwr;
    logic       regdst;
    logic       memtoreg;
    logic       regwr;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluctr;
    logic       extop;
    logic       ill;
    logic       retire;
  } ov_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = 6'd0, func = 6'd0;
  logic        mem_ready = 1'b1;
  logic        PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, MemtoReg, RegWr;
  logic        ALUSrcA, ExtOp, ill, retire;
  logic [1:0]  PCSrc, ALUSrcB;
  logic [2:0]  ALUctr;
  logic [31:0] instr_cnt;

  ov_t         act, exp_v = '0;
  logic [31:0] exp_cnt = '0;
  int          n_cmp = 0, n_bad = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .mem_ready(mem_ready),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc), .IorD(IorD),
    .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWr(RegWr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUctr(ALUctr), .ExtOp(ExtOp), .ill(ill), .retire(retire),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign act = {PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegDst,
                MemtoReg, RegWr, ALUSrcA, ALUSrcB, ALUctr, ExtOp, ill, retire};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("outs", {12'd0, act}, {12'd0, exp_v});
    chk("instr_cnt", instr_cnt, exp_cnt);
  end

  function automatic int klass(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: return (f inside {6'b100000, 6'b100010, 6'b100011, 6'b100100,
                                   6'b100101, 6'b101010, 6'b101011}) ? K_R : K_ILL;
      6'b001100, 6'b001101, 6'b001000, 6'b001001: return K_I;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  // {extop, aluctr} the instruction needs in its execute step
  function automatic logic [3:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) begin
      case (f)
        6'b100010, 6'b100011: return 4'b0001;
        6'b100100:            return 4'b0010;
        6'b100101:            return 4'b0011;
        6'b101010, 6'b101011: return 4'b0100;
        default:              return 4'b0000;
      endcase
    end
    case (o)
      6'b001100: return 4'b0010;
      6'b001101: return 4'b0011;
      default:   return 4'b1000;
    endcase
  endfunction

  function automatic ov_t f_fetch(input logic rdy);
    ov_t o = '0;
    o.memrd = 1'b1; o.alusrcb = 2'b01; o.irwr = rdy; o.pcwr = rdy;
    return o;
  endfunction

  // one clock: drive inputs and the expectation, retire bumps the count at the edge
  task automatic step(input ov_t e, input logic rdy);
    mem_ready = rdy;
    exp_v = e;
    @(posedge clk);
    if (e.retire) exp_cnt = exp_cnt + 32'd1;
    #1;
  endtask

  task automatic run(input logic [5:0] o_, input logic [5:0] f_, input int fw,
                     input int mw, output int cyc);
    ov_t e;
    int k;
    logic [3:0] xa;
    op = o_; func = f_; cyc = 0;
    k = klass(o_, f_);
    xa = alu_of(o_, f_);
    for (int i = 0; i < fw; i++) begin step(f_fetch(1'b0), 1'b0); cyc++; end
    step(f_fetch(1'b1), 1'b1); cyc++;
    e = '0; e.alusrcb = 2'b11; e.extop = 1'b1; e.ill = (k == K_ILL);
    step(e, 1'b1); cyc++;
    case (k)
      K_R: begin
        e = '0; e.alusrca = 1'b1; e.aluctr = xa[2:0];
        step(e, 1'b1); cyc++;
        e = '0; e.regdst = 1'b1; e.regwr = 1'b1; e.retire = 1'b1;
        step(e, 1'b1); cyc++;
      end
      K_I: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctr = xa[2:0]; e.extop = xa[3];
        step(e, 1'b1); cyc++;
        e = '0; e.regwr = 1'b1; e.retire = 1'b1;
        step(e, 1'b1); cyc++;
      end
      K_LW, K_SW: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.extop = 1'b1;
        step(e, 1'b1); cyc++;
        e = '0; e.iord = 1'b1;
        if (k == K_LW) e.memrd = 1'b1; else e.memwr = 1'b1;
        for (int i = 0; i < mw; i++) begin step(e, 1'b0); cyc++; end
        e.retire = (k == K_SW);
        step(e, 1'b1); cyc++;
        if (k == K_LW) begin
          e = '0; e.memtoreg = 1'b1; e.regwr = 1'b1; e.retire = 1'b1;
          step(e, 1'b1); cyc++;
        end
      end
      K_BEQ: begin
        e = '0; e.alusrca = 1'b1; e.aluctr = 3'b001; e.pcwrcond = 1'b1;
        e.pcsrc = 2'b01; e.retire = 1'b1;
        step(e, 1'b1); cyc++;
      end
      K_J: begin
        e = '0; e.pcwr = 1'b1; e.pcsrc = 2'b10; e.retire = 1'b1;
        step(e, 1'b1); cyc++;
      end
      default: ;
    endcase
  endtask

  initial begin
    int c;
    ov_t e;
    step('0, 1'b1);
    step('0, 1'b1);
    rst = 1'b0;

    run(6'b000000, 6'b100000, 0, 0, c); chk("cyc_add", c, 4);
    chk("cnt_after_add", instr_cnt, 32'd1);
    run(6'b100011, 6'b000000, 0, 2, c); chk("cyc_lw_wait2", c, 7);
    run(6'b101011, 6'b000000, 1, 1, c); chk("cyc_sw_waits", c, 6);
    run(6'b000100, 6'b000000, 0, 0, c); chk("cyc_beq", c, 3);
    run(6'b001101, 6'b000000, 0, 0, c); chk("cyc_ori", c, 4);
    run(6'b001100, 6'b000000, 0, 0, c);
    run(6'b001000, 6'b000000, 0, 0, c);
    run(6'b001001, 6'b000000, 0, 0, c);
    run(6'b000000, 6'b100010, 0, 0, c);
    run(6'b000000, 6'b100011, 0, 0, c);
    run(6'b000000, 6'b101010, 0, 0, c);
    run(6'b000000, 6'b101011, 0, 0, c);
    run(6'b000000, 6'b100100, 0, 0, c);
    run(6'b000000, 6'b100101, 0, 0, c);
    run(6'b000010, 6'b000000, 0, 0, c); chk("cyc_j", c, 3);
    chk("cnt_15", instr_cnt, 32'd15);

    run(6'b111111, 6'b000000, 0, 0, c); chk("cyc_ill_op", c, 2);
    run(6'b000000, 6'b000000, 0, 0, c); chk("cyc_ill_fn", c, 2);
    chk("cnt_ill_unchanged", instr_cnt, 32'd15);

    // sw stalled in MEMWR, then reset lands mid-cycle
    op = 6'b101011; func = 6'b000000;
    step(f_fetch(1'b1), 1'b1);
    e = '0; e.alusrcb = 2'b11; e.extop = 1'b1; step(e, 1'b1);
    e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.extop = 1'b1; step(e, 1'b1);
    e = '0; e.memwr = 1'b1; e.iord = 1'b1;
    mem_ready = 1'b0; exp_v = e;
    @(negedge clk); #1;
    chk("memwr_before_rst", {31'd0, MemWr}, 32'd1);
    rst = 1'b1; exp_v = '0; exp_cnt = '0;
    #1;
    chk("memwr_drop", {31'd0, MemWr}, 32'd0);
    chk("cnt_rst", instr_cnt, 32'd0);
    @(posedge clk); #1;
    step('0, 1'b0);
    rst = 1'b0;
    run(6'b000000, 6'b100000, 0, 0, c); chk("cyc_add_after_rst", c, 4);
    chk("cnt_after_rst", instr_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-subset CPU. A Moore state machine sequences the shared datapath (single ALU, unified instruction/data memory, IR, ALUOut/MDR registers) through fetch, decode, execute, memory and write-back steps. It supports variable memory latency through a ready handshake and reports retired and illegal instructions. It replaces the single-cycle decoder when the core runs in multi-cycle mode.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26], stable from the cycle after IRWr.
- func  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current access this cycle.
- PCWr  out  1  unconditional PC write.
- PCWrCond  out  1  PC write qualified externally by ALU Zero (beq).
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- IorD  out  1  0 memory address = PC, 1 memory address = ALUOut.
- MemRd  out  1  memory read request.
- MemWr  out  1  memory write request.
- IRWr  out  1  load IR.
- RegDst  out  1  1 rd, 0 rt.
- MemtoReg  out  1  write-back from MDR.
- RegWr  out  1  register file write.
- ALUSrcA  out  1  0 PC, 1 rs.
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 ext(imm), 11 sext(imm)<<2.
- ALUctr  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- ExtOp  out  1  1 sign-extend, 0 zero-extend.
- ill  out  1  1-cycle pulse on an illegal op/func.
- retire  out  1  1-cycle pulse when an instruction completes.
- instr_cnt  out  32  retired-instruction count, wraps at 2^32.

## Operation
- Supported: R-type add 100000, sub/subu 100010/100011, slt/sltu 101010/101011, and 100100, or 100101; andi 001100, ori 001101 (ExtOp=0); addi/addiu 001000/001001 (ExtOp=1); lw 100011; sw 101011; beq 000100; j 000010. Everything else is illegal.
- Each state asserts only the outputs listed for it; all other outputs are 0.
- FETCH: MemRd, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUctr=000. IRWr and PCWr (PCSrc=00) = mem_ready. Holds while !mem_ready; otherwise goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=000 (branch target into ALUOut). Next state: R-type → EXEC_R; andi/ori/addi/addiu → EXEC_I; lw/sw → ADDR; beq → BRANCH; j → JUMP; illegal → FETCH with ill=1.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUctr from func. Next: WB_R.
- WB_R: RegDst=1, RegWr. Next: FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUctr/ExtOp from op. Next: WB_I.
- WB_I: RegDst=0, RegWr. Next: FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUctr=000. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRd, IorD=1. Holds until mem_ready, then goes to WB_MEM.
- WB_MEM: RegDst=0, MemtoReg, RegWr. Next: FETCH.
- MEMWR: MemWr, IorD=1. Holds until mem_ready, then goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUctr=001, PCWrCond, PCSrc=01. Next: FETCH.
- JUMP: PCWr, PCSrc=10. Next: FETCH.
- retire is 1 in the final cycle of WB_R, WB_I, WB_MEM, BRANCH and JUMP, and in the mem_ready cycle of MEMWR. instr_cnt increments on that edge.
- An illegal instruction neither retires nor writes to the register file or memory.

## Timing
- Reset: state=FETCH, instr_cnt=0. While rst=1, every output is forced to 0, including the FETCH outputs.
- Fetch starts on the first rising edge after rst deasserts.
- Outputs are decoded combinationally from state, op, func and mem_ready. There are no registered outputs beyond state and instr_cnt.
- Cycle counts with zero-wait memory: R/I-ALU 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each !mem_ready cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- Reset asserted mid-instruction aborts it immediately: MemWr/RegWr drop asynchronously and no retire occurs.
- instr_cnt 0xFFFFFFFF wraps to 0 with retire=1.

## Structure
- mc_ctrl_pkg holds the state enum, opcode and funct constants, ALUctr codes, and ALUSrcB and PCSrc codes.
- Sub-module mc_alu_dec is combinational. It takes op and func and produces ALUctr, ExtOp and a legal flag. It is used in DECODE, EXEC_R and EXEC_I.

## Test plan
- Reset, mem_ready=1, op=000000, func=100000 → states FETCH/DECODE/EXEC_R/WB_R. ALUctr=000 in cycle 3; RegDst=1 and RegWr=1 in cycle 4; retire pulse; instr_cnt=1.
- lw (op=100011) with mem_ready=0 for 2 cycles in MEMRD → MemRd=IorD=1 for 3 cycles; 7 cycles total; MemtoReg=RegWr=1 in WB_MEM.
- beq (op=000100) → 3 cycles. Cycle 3 shows PCWrCond=1, PCSrc=01, ALUctr=001, ALUSrcA=1; retire=1.
- ori (op=001101) → EXEC_I shows ALUctr=011, ExtOp=0, ALUSrcB=10; RegDst=0 in WB_I.
- op=111111, then R-type func=000000 → ill=1 in DECODE each time. Returns to FETCH; RegWr and MemWr never assert; instr_cnt unchanged.
- rst pulsed during MEMWR with mem_ready=0 → MemWr=0 immediately. After release, state=FETCH and instr_cnt=0.
